// File: rtl/wbm_cmd_master.sv
// -----------------------------------------------------------------------------
// wbm_cmd_master
//   Wishbone classic-cycle initiator. Accepts one command at a time from a
//   valid/ready stream, runs a single Wishbone cycle and returns one response
//   (read data, or a timeout error when the slave never acknowledges).
//
// Parameters
//   BITS     data width (byte selects are BITS/8 wide)
//   TIMEOUT  bus cycles to wait for ack before reporting an error; 0 = wait forever
//   TO_W     width of the bus-cycle counter (must be able to hold TIMEOUT)
//
// Ports
//   wb_clk_i, wb_rst_i            clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready           command handshake (ready only while idle)
//   cmd_we/adr/dat/sel            command fields, sampled on acceptance
//   rsp_valid/rsp_ready           response handshake
//   rsp_dat/rsp_err               read data (0 for writes/errors), timeout flag
//   wbm_cyc_o/stb_o/we_o/sel_o/adr_o/dat_o   Wishbone master outputs
//   wbm_ack_i/dat_i               Wishbone slave acknowledge and read data
//   busy                          a command is in flight
// -----------------------------------------------------------------------------
module wbm_cmd_master #(
  parameter int BITS    = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [31:0]       cmd_adr,
  input  logic [BITS-1:0]   cmd_dat,
  input  logic [BITS/8-1:0] cmd_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [BITS-1:0]   rsp_dat,
  output logic              rsp_err,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [BITS/8-1:0] wbm_sel_o,
  output logic [31:0]       wbm_adr_o,
  output logic [BITS-1:0]   wbm_dat_o,
  input  logic              wbm_ack_i,
  input  logic [BITS-1:0]   wbm_dat_i,
  output logic              busy
);

  localparam int SEL_W = BITS / 8;
  localparam logic [TO_W-1:0] CNT_MAX = '1;
  localparam logic [TO_W-1:0] TO_VAL  = TO_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [31:0]       adr_q, adr_d;
  logic [BITS-1:0]   dat_q, dat_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [BITS-1:0]   rsp_dat_q, rsp_dat_d;
  logic              rsp_err_q, rsp_err_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;

  // Number of the BUS cycle that ends at the coming edge; saturates so a
  // disabled timeout can never wrap back onto a matching value.
  logic [TO_W-1:0] cnt_inc;
  logic            ack_hit;
  logic            to_hit;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + TO_W'(1);
  assign ack_hit = (state_q == S_BUS) && wbm_ack_i;
  // An ack in the final allowed cycle takes priority over the timeout.
  assign to_hit  = (TIMEOUT != 0) && (state_q == S_BUS) && !wbm_ack_i &&
                   (cnt_inc == TO_VAL);

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (cmd_valid)           state_d = S_BUS;
      S_BUS:  if (ack_hit || to_hit)   state_d = S_RESP;
      S_RESP: if (rsp_ready)           state_d = S_IDLE;
      default:                         state_d = S_IDLE;
    endcase
  end

  // Output / datapath next-state logic
  always_comb begin
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cyc_d = 1'b1;
          we_d  = cmd_we;
          sel_d = cmd_sel;
          adr_d = cmd_adr;
          dat_d = cmd_dat;
        end
      end
      S_BUS: begin
        cnt_d = cnt_inc;
        if (ack_hit) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_dat_d   = we_q ? '0 : wbm_dat_i;
        end else if (to_hit) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = '0;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cnt_d       = '0;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs
  // NOTE: the data/address registers are reset too, so the bus shows all-zero
  // fields after reset rather than leftover garbage.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;

endmodule
